cpu_adapter_pipe: RTL and testbench
===================================

# cpu_adapter_pipe

Parametrised, pipelined read adapter between a packet-filter CPU's load port and the packet buffer's wide read port. It converts a byte address plus transfer size (byte, half, word) into a word-address memory read. It then extracts the addressed bytes, big-endian and possibly unaligned, from the returned double-word ("bigword"), and zero-extends them to 32 bits. Unlike the single-outstanding adapter, it supports up to DEPTH in-order outstanding reads with a ready handshake, selectable in/out registering, and an invalid-size error flag.

## Interface
- BYTE_ADDR_WIDTH, 12, width of CPU byte address.
- ADDR_WIDTH, 10, width of memory word address.
  - W = 2^(BYTE_ADDR_WIDTH-ADDR_WIDTH) bytes per word; W must be ≥ 4.
  - Bigword width is 2·W·8 bits.
- DEPTH, 4, maximum outstanding reads; power of 2, ≥ 2.
- BUF_IN, 1, 1 = register the request stage; 0 = combinational request path.
- BUF_OUT, 1, 1 = register the output stage; 0 = combinational output path.
- PESS, 1, 1 = cpu_rd_rdy depends on registered count only; 0 = a pop in the same cycle frees a slot.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- byte_rd_addr  in  BYTE_ADDR_WIDTH  CPU byte address.
- cpu_rd_en  in  1  request strobe; accepted when cpu_rd_en & cpu_rd_rdy.
- transfer_sz  in  2  00 byte, 01 half, 10 word, 11 invalid.
- cpu_rd_rdy  out  1  adapter can accept a request.
- rd_en  out  1  memory read strobe.
- word_rd_addra  out  ADDR_WIDTH  byte_rd_addr >> log2(W).
- bigword  in  2·W·8  contents of words addr and addr+1; byte 0 (lowest address) is the MSB byte.
- bigword_vld  in  1  memory response; responses arrive in request order.
- resized_mem_data  out  32  extracted data, zero-extended.
- resized_mem_data_vld  out  1  one-cycle valid pulse.
- resized_mem_err  out  1  qualifies the valid pulse; 1 = invalid transfer_sz.

## Operation
- Accept request: push {offset = byte_rd_addr[log2(W)-1:0], transfer_sz} into the metadata FIFO (DEPTH entries, circular rd/wr pointers, count of log2(DEPTH)+1 bits).
- Issue the memory read at the same time: rd_en=1, word_rd_addra=byte_rd_addr>>log2(W).
- Invalid size (11) still issues the read and is pushed, so response ordering is preserved.
- On bigword_vld with count>0: pop the head entry and extract n = 1/2/4 bytes starting at byte `offset` of bigword.
  - Result is right-justified and zero-extended: `(bigword << offset·8)` takes the top n·8 bits.
  - For an invalid entry: data = 0 and err = 1.
- bigword_vld with count=0 is a stray response. It is ignored: no pop, no output.
- Outstanding count includes a request held in the BUF_IN register.
- Ready rule:
  - PESS=1: cpu_rd_rdy = rst & (count < DEPTH).
  - PESS=0: additionally high when count = DEPTH and bigword_vld is high this cycle.
- Simultaneous push and pop: count unchanged; pointers both advance.
- Reset (async, any time) clears:
  - FIFO pointers and count;
  - rd_en, word_rd_addra = 0;
  - resized_mem_data = 0, resized_mem_data_vld = 0, resized_mem_err = 0;
  - cpu_rd_rdy = 0 while rst is low.
  - In-flight responses arriving after reset release are strays and are dropped.

## Timing
- Request path:
  - BUF_IN=1: rd_en and word_rd_addra are registered and appear 1 cycle after acceptance.
  - BUF_IN=0: rd_en and word_rd_addra are combinational, in the same cycle as acceptance.
- Response path:
  - BUF_OUT=1: the vld pulse, data and err appear 1 cycle after bigword_vld.
  - BUF_OUT=0: they appear in the same cycle as bigword_vld.
- Total adapter latency is BUF_IN + BUF_OUT cycles plus the memory latency.
- Throughput is one request and one response per cycle.
- resized_mem_data holds its last value when vld is low; resized_mem_err is 0 when vld is low.
- The first cycle after rst rises: cpu_rd_rdy=1.

## Test plan
Defaults (W=4, 64-bit bigword); memory model latency 3, in-order.
- Aligned word:
  - Stimulus: byte_rd_addr=0x008, sz=10.
  - word_rd_addra=0x002; bigword=0x1122334455667788 → data 0x11223344, err=0.
- Unaligned word:
  - Stimulus: addr=0x00D, sz=10.
  - word_rd_addra=0x003; bigword=0xAABBCCDDEEFF0011 → data 0xBBCCDDEE.
- Byte/half:
  - addr=0x00F, bigword=0x0102030405060708.
  - sz=00 → 0x00000004; sz=01 → 0x00000405.
- Back-pressure (PESS=1):
  - Stimulus: 5 back-to-back requests.
  - cpu_rd_rdy falls after the 4th is accepted and rises the cycle after the first pop.
  - Outputs appear in request order, one per response.
- Invalid size:
  - Stimulus: sz=11 at addr 0x004.
  - rd_en still fires; response → data 0x00000000, err=1, vld=1.
- Reset mid-flight:
  - Stimulus: 2 outstanding, pulse rst low.
  - All outputs are 0, cpu_rd_rdy=0 during reset.
  - Later bigword_vld pulses produce no resized_mem_data_vld; the next new request is returned correctly.

Source files
------------

// File: rtl/cpu_adapter_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cpu_adapter_pipe
// Purpose  : Pipelined CPU load-port to wide packet-buffer read adapter with
//            up to DEPTH in-order outstanding reads and big-endian extraction.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_adapter_pipe #(
  parameter int BYTE_ADDR_WIDTH = 12,
  parameter int ADDR_WIDTH      = 10,
  parameter int DEPTH           = 4,
  parameter int BUF_IN          = 1,
  parameter int BUF_OUT         = 1,
  parameter int PESS            = 1
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic [BYTE_ADDR_WIDTH-1:0]                         byte_rd_addr,
  input  logic                                               cpu_rd_en,
  input  logic [1:0]                                         transfer_sz,
  output logic                                               cpu_rd_rdy,
  output logic                                               rd_en,
  output logic [ADDR_WIDTH-1:0]                              word_rd_addra,
  input  logic [2*(2**(BYTE_ADDR_WIDTH-ADDR_WIDTH))*8-1:0]   bigword,
  input  logic                                               bigword_vld,
  output logic [31:0]                                        resized_mem_data,
  output logic                                               resized_mem_data_vld,
  output logic                                               resized_mem_err
);

  localparam int c_OFF_W = BYTE_ADDR_WIDTH - ADDR_WIDTH;
  localparam int c_W     = 1 << c_OFF_W;
  localparam int c_BW    = 2 * c_W * 8;
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

  localparam logic [1:0] c_SZ_BYTE = 2'b00;
  localparam logic [1:0] c_SZ_HALF = 2'b01;
  localparam logic [1:0] c_SZ_WORD = 2'b10;

  logic [c_OFF_W-1:0]    r_off [DEPTH];
  logic [1:0]            r_sz  [DEPTH];
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_CNT_W-1:0]    r_count;

  logic                  w_rdy;
  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH-1:0] w_word_addr;
  logic [c_OFF_W-1:0]    w_head_off;
  logic [1:0]            w_head_sz;
  logic [31:0]           w_top;
  logic [31:0]           w_data;
  logic                  w_err;

  assign cpu_rd_rdy  = w_rdy;
  assign w_push      = cpu_rd_en & w_rdy;
  // A response with nothing outstanding is a stray (e.g. issued before reset).
  assign w_pop       = bigword_vld & (r_count != '0);
  assign w_word_addr = byte_rd_addr[BYTE_ADDR_WIDTH-1:c_OFF_W];
  assign w_head_off  = r_off[r_rd_ptr];
  assign w_head_sz   = r_sz[r_rd_ptr];

  generate
    if (PESS != 0) begin : g_rdy_pess
      assign w_rdy = rst & (r_count < c_DEPTH);
    end else begin : g_rdy_opt
      assign w_rdy = rst & ((r_count < c_DEPTH) | ((r_count == c_DEPTH) & bigword_vld));
    end
  endgenerate

  // Metadata storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_off[r_wr_ptr] <= byte_rd_addr[c_OFF_W-1:0];
      r_sz[r_wr_ptr]  <= transfer_sz;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - c_CNT_W'(1);
      end
    end
  end

  // Byte 0 of the bigword is its MSB byte, so the addressed field starts
  // offset bytes down from the top; W >= 4 keeps the 32-bit window in range.
  always_comb begin
    w_top  = bigword[(c_BW - 1) - 8 * int'(w_head_off) -: 32];
    w_data = '0;
    w_err  = 1'b0;
    case (w_head_sz)
      c_SZ_BYTE: w_data = {24'd0, w_top[31:24]};
      c_SZ_HALF: w_data = {16'd0, w_top[31:16]};
      c_SZ_WORD: w_data = w_top;
      default:   w_err  = 1'b1;
    endcase
  end

  generate
    if (BUF_IN != 0) begin : g_buf_in
      logic                  r_rd_en;
      logic [ADDR_WIDTH-1:0] r_word_addr;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_rd_en     <= 1'b0;
          r_word_addr <= '0;
        end else begin
          r_rd_en <= w_push;
          if (w_push) begin
            r_word_addr <= w_word_addr;
          end
        end
      end

      assign rd_en         = r_rd_en;
      assign word_rd_addra = r_word_addr;
    end else begin : g_comb_in
      assign rd_en         = w_push;
      assign word_rd_addra = rst ? w_word_addr : '0;
    end
  endgenerate

  generate
    if (BUF_OUT != 0) begin : g_buf_out
      logic        r_vld;
      logic        r_err;
      logic [31:0] r_data;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_vld  <= 1'b0;
          r_err  <= 1'b0;
          r_data <= '0;
        end else begin
          r_vld <= w_pop;
          r_err <= w_pop & w_err;
          if (w_pop) begin
            r_data <= w_data;
          end
        end
      end

      assign resized_mem_data_vld = r_vld;
      assign resized_mem_err      = r_err;
      assign resized_mem_data     = r_data;
    end else begin : g_comb_out
      // Holds the last delivered value so data stays stable while vld is low.
      logic [31:0] r_hold;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_hold <= '0;
        end else if (w_pop) begin
          r_hold <= w_data;
        end
      end

      assign resized_mem_data_vld = w_pop;
      assign resized_mem_err      = w_pop & w_err;
      assign resized_mem_data     = w_pop ? w_data : r_hold;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_cpu_adapter_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_adapter_pipe
// Purpose  : Self-checking bench for cpu_adapter_pipe with a latency-3 memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_adapter_pipe;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] byte_rd_addr = '0;
  logic        cpu_rd_en = 1'b0;
  logic [1:0]  transfer_sz = '0;
  logic        cpu_rd_rdy;
  logic        rd_en;
  logic [9:0]  word_rd_addra;
  logic [63:0] bigword = '0;
  logic        bigword_vld = 1'b0;
  logic [31:0] resized_mem_data;
  logic        resized_mem_data_vld;
  logic        resized_mem_err;

  always #5 clk = ~clk;

  cpu_adapter_pipe #(
    .BYTE_ADDR_WIDTH(12), .ADDR_WIDTH(10), .DEPTH(DEPTH),
    .BUF_IN(1), .BUF_OUT(1), .PESS(1)
  ) dut (
    .clk(clk), .rst(rst), .byte_rd_addr(byte_rd_addr), .cpu_rd_en(cpu_rd_en),
    .transfer_sz(transfer_sz), .cpu_rd_rdy(cpu_rd_rdy), .rd_en(rd_en),
    .word_rd_addra(word_rd_addra), .bigword(bigword), .bigword_vld(bigword_vld),
    .resized_mem_data(resized_mem_data), .resized_mem_data_vld(resized_mem_data_vld),
    .resized_mem_err(resized_mem_err)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [1024];
  typedef struct { logic [9:0] a; int due; } pend_t;
  pend_t       pend[$];
  int          cyc = 0;
  logic [9:0]  obs_addr[$];
  logic [31:0] obs_data[$];
  logic        obs_err[$];
  logic [9:0]  exp_addr[$];
  logic [31:0] exp_data[$];
  logic        exp_err[$];

  // Memory: read seen in cycle k is answered in cycle k+3, in order.
  initial begin : mem_model
    pend_t      p;
    logic [9:0] a1;
    forever begin
      @(negedge clk);
      cyc++;
      bigword_vld = 1'b0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        p  = pend.pop_front();
        a1 = p.a + 10'd1;
        bigword     = {mem[p.a], mem[a1]};
        bigword_vld = 1'b1;
      end
      if (rd_en) begin
        pend.push_back('{word_rd_addra, cyc + 3});
        obs_addr.push_back(word_rd_addra);
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (resized_mem_data_vld) begin
        obs_data.push_back(resized_mem_data);
        obs_err.push_back(resized_mem_err);
      end
    end
  end

  // Reference: the loaded value is the n bytes at CPU byte addresses
  // addr..addr+n-1 read from a byte-addressed big-endian view of memory.
  function automatic logic [7:0] mem_byte(input logic [11:0] b);
    logic [31:0] w;
    int          sh;
    w  = mem[b[11:2]];
    sh = 24 - 8 * int'(b[1:0]);
    return 8'(w >> sh);
  endfunction

  function automatic void ref_load(input logic [11:0] addr, input logic [1:0] sz,
                                   output logic [31:0] d, output logic e);
    int n;
    d = '0;
    e = (sz == 2'b11);
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 0;
    for (int i = 0; i < n; i++) begin
      d = (d << 8) | {24'd0, mem_byte(addr + 12'(i))};
    end
  endfunction

  task automatic clear_q();
    obs_addr.delete(); obs_data.delete(); obs_err.delete();
    exp_addr.delete(); exp_data.delete(); exp_err.delete();
  endtask

  task automatic issue(input logic [11:0] a, input logic [1:0] s);
    logic [31:0] d;
    logic        e;
    int          budget;
    @(negedge clk); #1;
    byte_rd_addr = a; transfer_sz = s; cpu_rd_en = 1'b1;
    budget = 100;
    while (!cpu_rd_rdy && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    if (!cpu_rd_rdy) begin
      vectors++; miscompares++;
      $display("FAIL issue_timeout: cpu_rd_rdy stayed %b, want 1", cpu_rd_rdy);
      cpu_rd_en = 1'b0;
    end else begin
      ref_load(a, s, d, e);
      exp_addr.push_back(a[11:2]);
      exp_data.push_back(d);
      exp_err.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk); #1;
    cpu_rd_en = 1'b0;
  endtask

  task automatic wait_drain();
    int budget = 300;
    while ((obs_data.size() < exp_data.size() || pend.size() > 0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (3) @(negedge clk);
    if (budget == 0) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: got %0d responses, want %0d", obs_data.size(), exp_data.size());
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (cpu_rd_rdy !== 1'b0 || rd_en !== 1'b0 || word_rd_addra !== 10'h0) begin
      miscompares++;
      $display("FAIL reset_req: rdy %b rd_en %b addr %h, want 0 0 000", cpu_rd_rdy, rd_en, word_rd_addra);
    end
    vectors++;
    if (resized_mem_data !== 32'h0 || resized_mem_data_vld !== 1'b0 || resized_mem_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out: data %h vld %b err %b, want 0 0 0", resized_mem_data, resized_mem_data_vld, resized_mem_err);
    end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (cpu_rd_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_rdy: got %b, want 1", cpu_rd_rdy);
    end
  endtask

  task automatic test_aligned_word();
    clear_q();
    mem[2] = 32'h11223344; mem[3] = 32'h55667788;
    issue(12'h008, 2'b10);
    idle();
    wait_drain();
    vectors++;
    if (obs_addr.size() != 1 || obs_addr[0] !== 10'h002) begin
      miscompares++;
      $display("FAIL aligned_addr: got %0d reads first %h, want 1 read 002", obs_addr.size(), obs_addr.size() > 0 ? obs_addr[0] : 10'h3ff);
    end
    vectors++;
    if (obs_data.size() != 1 || obs_data[0] !== 32'h11223344 || obs_err[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL aligned_data: got %0d resp first %h, want 1 resp 11223344 err 0", obs_data.size(), obs_data.size() > 0 ? obs_data[0] : 32'hx);
    end
  endtask

  task automatic test_unaligned_word();
    clear_q();
    mem[3] = 32'hAABBCCDD; mem[4] = 32'hEEFF0011;
    issue(12'h00D, 2'b10);
    idle();
    wait_drain();
    vectors++;
    if (obs_addr.size() != 1 || obs_addr[0] !== 10'h003) begin
      miscompares++;
      $display("FAIL unaligned_addr: got %0d reads first %h, want 1 read 003", obs_addr.size(), obs_addr.size() > 0 ? obs_addr[0] : 10'h3ff);
    end
    vectors++;
    if (obs_data.size() != 1 || obs_data[0] !== 32'hBBCCDDEE || obs_err[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL unaligned_data: got %0d resp first %h, want 1 resp bbccddee err 0", obs_data.size(), obs_data.size() > 0 ? obs_data[0] : 32'hx);
    end
  endtask

  task automatic test_byte_half();
    clear_q();
    mem[3] = 32'h01020304; mem[4] = 32'h05060708;
    issue(12'h00F, 2'b00);
    issue(12'h00F, 2'b01);
    idle();
    wait_drain();
    vectors++;
    if (obs_data.size() != 2) begin
      miscompares++;
      $display("FAIL byte_half_count: got %0d responses, want 2", obs_data.size());
    end else begin
      vectors++;
      if (obs_data[0] !== 32'h00000004 || obs_err[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL byte_data: got %h err %b, want 00000004 err 0", obs_data[0], obs_err[0]);
      end
      vectors++;
      if (obs_data[1] !== 32'h00000405 || obs_err[1] !== 1'b0) begin
        miscompares++;
        $display("FAIL half_data: got %h err %b, want 00000405 err 0", obs_data[1], obs_err[1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] a [5];
    logic [1:0]  s [5];
    logic [31:0] d;
    logic        e;
    logic        exp_rdy;
    logic        acc;
    int          outstanding = 0;
    int          sent = 0;
    int          budget = 60;
    clear_q();
    for (int i = 0; i < 5; i++) begin
      a[i] = 12'($urandom);
      s[i] = 2'($urandom_range(0, 2));
    end
    while (sent < 5 && budget > 0) begin
      @(negedge clk); #1;
      byte_rd_addr = a[sent]; transfer_sz = s[sent]; cpu_rd_en = 1'b1;
      exp_rdy = (outstanding < DEPTH);
      vectors++;
      if (cpu_rd_rdy !== exp_rdy) begin
        miscompares++;
        $display("FAIL bp_rdy[req%0d,out%0d]: got %b, want %b", sent, outstanding, cpu_rd_rdy, exp_rdy);
      end
      acc = cpu_rd_rdy;
      if (bigword_vld && outstanding > 0) outstanding--;
      if (acc) begin
        ref_load(a[sent], s[sent], d, e);
        exp_data.push_back(d); exp_err.push_back(e);
        sent++;
        outstanding++;
      end
      budget--;
    end
    idle();
    wait_drain();
    vectors++;
    if (obs_data.size() != exp_data.size()) begin
      miscompares++;
      $display("FAIL bp_count: got %0d responses, want %0d", obs_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      vectors++;
      if (obs_data[i] !== exp_data[i] || obs_err[i] !== exp_err[i]) begin
        miscompares++;
        $display("FAIL bp_data[%0d]: got %h err %b, want %h err %b", i, obs_data[i], obs_err[i], exp_data[i], exp_err[i]);
      end
    end
  endtask

  task automatic test_invalid();
    clear_q();
    issue(12'h004, 2'b11);
    idle();
    wait_drain();
    vectors++;
    if (obs_addr.size() != 1 || obs_addr[0] !== 10'h001) begin
      miscompares++;
      $display("FAIL invalid_rd: got %0d reads first %h, want 1 read 001", obs_addr.size(), obs_addr.size() > 0 ? obs_addr[0] : 10'h3ff);
    end
    vectors++;
    if (obs_data.size() != 1 || obs_data[0] !== 32'h0 || obs_err[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL invalid_resp: got %0d resp first %h, want 1 resp 00000000 err 1", obs_data.size(), obs_data.size() > 0 ? obs_data[0] : 32'hx);
    end
  endtask

  task automatic test_reset_midflight();
    int budget = 50;
    clear_q();
    issue(12'($urandom), 2'b10);
    issue(12'($urandom), 2'b01);
    idle();
    while (pend.size() < 2 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    #1 rst = 1'b0;
    #1;
    vectors++;
    if (cpu_rd_rdy !== 1'b0 || rd_en !== 1'b0 || word_rd_addra !== 10'h0 ||
        resized_mem_data !== 32'h0 || resized_mem_data_vld !== 1'b0 || resized_mem_err !== 1'b0) begin
      miscompares++;
      $display("FAIL midflight_reset: rdy %b rd_en %b addr %h data %h vld %b err %b, want all 0",
               cpu_rd_rdy, rd_en, word_rd_addra, resized_mem_data, resized_mem_data_vld, resized_mem_err);
    end
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    clear_q();
    wait_drain();
    vectors++;
    if (obs_data.size() != 0) begin
      miscompares++;
      $display("FAIL stray_dropped: got %0d responses, want 0", obs_data.size());
    end
    mem[10'h020] = 32'hDEADBEEF; mem[10'h021] = 32'hCAFEF00D;
    issue(12'h082, 2'b10);
    idle();
    wait_drain();
    vectors++;
    if (obs_data.size() != 1 || obs_data[0] !== 32'hBEEFCAFE || obs_err[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_data: got %0d resp first %h, want 1 resp beefcafe err 0", obs_data.size(), obs_data.size() > 0 ? obs_data[0] : 32'hx);
    end
  endtask

  task automatic test_random();
    clear_q();
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    for (int n = 0; n < 40; n++) begin
      issue(12'($urandom), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle();
    wait_drain();
    vectors++;
    if (obs_data.size() != exp_data.size() || obs_addr.size() != exp_addr.size()) begin
      miscompares++;
      $display("FAIL rand_count: got %0d resp %0d reads, want %0d resp %0d reads",
               obs_data.size(), obs_addr.size(), exp_data.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size() && i < obs_addr.size(); i++) begin
      vectors++;
      if (obs_data[i] !== exp_data[i] || obs_err[i] !== exp_err[i] || obs_addr[i] !== exp_addr[i]) begin
        miscompares++;
        $display("FAIL rand_resp[%0d]: got addr %h data %h err %b, want addr %h data %h err %b",
                 i, obs_addr[i], obs_data[i], obs_err[i], exp_addr[i], exp_data[i], exp_err[i]);
      end
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    test_reset();
    test_aligned_word();
    test_unaligned_word();
    test_byte_half();
    test_back_to_back();
    test_invalid();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
